// File: rtl/ale_pkg.sv
// Shared definitions for the atmospheric light estimator: frame defaults,
// pixel field layout and the reciprocal saturation value.
package ale_pkg;

    localparam int unsigned IMG_WIDTH_DEF  = 512;
    localparam int unsigned IMG_HEIGHT_DEF = 512;

    localparam int unsigned CH_W      = 8;
    localparam int unsigned PIX_R_LSB = 16;
    localparam int unsigned PIX_G_LSB = 8;
    localparam int unsigned PIX_B_LSB = 0;

    localparam logic [15:0] INV_SAT = 16'hFFFF;

    typedef struct packed {
        logic [CH_W-1:0] r;
        logic [CH_W-1:0] g;
        logic [CH_W-1:0] b;
    } rgb_t;

    function automatic rgb_t unpack_pixel(input logic [23:0] p);
        rgb_t v;
        v.r = p[PIX_R_LSB +: CH_W];
        v.g = p[PIX_G_LSB +: CH_W];
        v.b = p[PIX_B_LSB +: CH_W];
        return v;
    endfunction

    function automatic logic [CH_W-1:0] dark_of(input rgb_t p);
        logic [CH_W-1:0] m;
        m = (p.r < p.g) ? p.r : p.g;
        return (m < p.b) ? m : p.b;
    endfunction

endpackage

// File: rtl/ale_recip.sv
// Registered Q0.16 reciprocal of an 8-bit value; saturates for inputs 0 and 1.
module ale_recip
    import ale_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  i_a,
    output logic [15:0] o_inv
);

    logic        w_small;
    logic [16:0] w_quot;
    logic [15:0] w_inv;

    // Divisor is clamped to 2 for small inputs so the divider never sees zero.
    always_comb begin
        w_small = (i_a < 8'd2);
        w_quot  = 17'h10000 / {9'd0, (w_small ? 8'd2 : i_a)};
        w_inv   = (w_small || w_quot[16]) ? INV_SAT : w_quot[15:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_inv <= '0;
        end else begin
            o_inv <= w_inv;
        end
    end

endmodule

// File: rtl/ale_top.sv
// Atmospheric light estimator: per frame, reports the RGB of the earliest
// pixel with the largest dark channel, plus per-channel reciprocals.
module ale_top
    import ale_pkg::*;
#(
    parameter int unsigned IMG_WIDTH  = IMG_WIDTH_DEF,
    parameter int unsigned IMG_HEIGHT = IMG_HEIGHT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] input_pixel,
    input  logic        input_is_valid,
    output logic [7:0]  A_R,
    output logic [7:0]  A_G,
    output logic [7:0]  A_B,
    output logic [15:0] Inv_A_R,
    output logic [15:0] Inv_A_G,
    output logic [15:0] Inv_A_B,
    output logic        output_is_valid
);

    localparam int unsigned FRAME_PIXELS = IMG_WIDTH * IMG_HEIGHT;
    localparam int unsigned CNT_W        = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_PIXELS - 1);

    logic [CNT_W-1:0] r_cnt;

    logic             r_s1_valid;
    logic             r_s1_first;
    logic             r_s1_last;
    rgb_t             r_s1_pix;
    logic [CH_W-1:0]  r_s1_dark;

    rgb_t             r_max_pix;
    logic [CH_W-1:0]  r_max_dark;
    rgb_t             r_s2_win;
    logic             r_s2_valid;

    rgb_t             r_s3_a;
    logic             r_s3_valid;

    logic             w_take;
    rgb_t             w_win_pix;
    logic [CH_W-1:0]  w_win_dark;
    logic [15:0]      w_inv_r;
    logic [15:0]      w_inv_g;
    logic [15:0]      w_inv_b;

    // Stage 1: pixel counter, dark value and frame position flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt      <= '0;
            r_s1_valid <= 1'b0;
            r_s1_first <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_pix   <= '0;
            r_s1_dark  <= '0;
        end else begin
            r_s1_valid <= input_is_valid;
            if (input_is_valid) begin
                r_s1_pix   <= unpack_pixel(input_pixel);
                r_s1_dark  <= dark_of(unpack_pixel(input_pixel));
                r_s1_first <= (r_cnt == '0);
                r_s1_last  <= (r_cnt == LAST_IDX);
                r_cnt      <= (r_cnt == LAST_IDX) ? '0 : r_cnt + CNT_W'(1);
            end
        end
    end

    // Strict compare keeps the earliest maximum; the first pixel always loads.
    always_comb begin
        w_take     = r_s1_first || (r_s1_dark > r_max_dark);
        w_win_pix  = w_take ? r_s1_pix  : r_max_pix;
        w_win_dark = w_take ? r_s1_dark : r_max_dark;
    end

    // Stage 2: max tracking; the frame winner is latched separately so the
    // next frame can start loading the tracker immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_max_pix  <= '0;
            r_max_dark <= '0;
            r_s2_win   <= '0;
            r_s2_valid <= 1'b0;
        end else begin
            r_s2_valid <= r_s1_valid && r_s1_last;
            if (r_s1_valid) begin
                r_max_pix  <= w_win_pix;
                r_max_dark <= w_win_dark;
                if (r_s1_last) begin
                    r_s2_win <= w_win_pix;
                end
            end
        end
    end

    // Stage 3: reciprocals, aligned with a delayed copy of the winner.
    ale_recip u_recip_r (.clk(clk), .rst(rst), .i_a(r_s2_win.r), .o_inv(w_inv_r));
    ale_recip u_recip_g (.clk(clk), .rst(rst), .i_a(r_s2_win.g), .o_inv(w_inv_g));
    ale_recip u_recip_b (.clk(clk), .rst(rst), .i_a(r_s2_win.b), .o_inv(w_inv_b));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s3_a     <= '0;
            r_s3_valid <= 1'b0;
        end else begin
            r_s3_a     <= r_s2_win;
            r_s3_valid <= r_s2_valid;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            A_R             <= '0;
            A_G             <= '0;
            A_B             <= '0;
            Inv_A_R         <= '0;
            Inv_A_G         <= '0;
            Inv_A_B         <= '0;
            output_is_valid <= 1'b0;
        end else begin
            output_is_valid <= r_s3_valid;
            if (r_s3_valid) begin
                A_R     <= r_s3_a.r;
                A_G     <= r_s3_a.g;
                A_B     <= r_s3_a.b;
                Inv_A_R <= w_inv_r;
                Inv_A_G <= w_inv_g;
                Inv_A_B <= w_inv_b;
            end
        end
    end

endmodule

// File: tb/tb_ale_top.sv
// Directed bench for ale_top on a 4x4 frame with hand-computed results.
module tb_ale_top;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [23:0] input_pixel = '0;
    logic        input_is_valid = 1'b0;
    logic [7:0]  A_R, A_G, A_B;
    logic [15:0] Inv_A_R, Inv_A_G, Inv_A_B;
    logic        output_is_valid;

    ale_top #(.IMG_WIDTH(4), .IMG_HEIGHT(4)) dut (
        .clk(clk), .rst(rst),
        .input_pixel(input_pixel), .input_is_valid(input_is_valid),
        .A_R(A_R), .A_G(A_G), .A_B(A_B),
        .Inv_A_R(Inv_A_R), .Inv_A_G(Inv_A_G), .Inv_A_B(Inv_A_B),
        .output_is_valid(output_is_valid)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned n_pulse  = 0;
    int unsigned n_hold_viol = 0;
    int unsigned t_last = 0;
    int unsigned pt [4];
    logic [23:0] pa [4];
    logic [71:0] prev_out = '0;
    logic [23:0] fb [16];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulse log and check that outputs only change together with a pulse.
    always @(negedge clk) begin
        if (rst) begin
            if (output_is_valid) begin
                if (n_pulse < 4) begin
                    pt[n_pulse] = cyc;
                    pa[n_pulse] = {A_R, A_G, A_B};
                end
                n_pulse++;
            end else if ({A_R, A_G, A_B, Inv_A_R, Inv_A_G, Inv_A_B} !== prev_out) begin
                n_hold_viol++;
            end
        end
        prev_out = {A_R, A_G, A_B, Inv_A_R, Inv_A_G, Inv_A_B};
    end

    task automatic drive(input logic [23:0] p, input logic v);
        @(negedge clk);
        input_pixel    = p;
        input_is_valid = v;
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) drive(24'h0, 1'b0);
    endtask

    task automatic fill(input logic [23:0] bg);
        for (int i = 0; i < 16; i++) fb[i] = bg;
    endtask

    task automatic send_frame(input bit gaps);
        for (int i = 0; i < 16; i++) begin
            if (gaps) idle($urandom_range(0, 2));
            drive(fb[i], 1'b1);
        end
        t_last = cyc;
    endtask

    task automatic check_result(input string tag, input logic [23:0] a,
                                input logic [15:0] ir, input logic [15:0] ig, input logic [15:0] ib);
        chk({tag, " pulses"},  n_pulse, 1);
        chk({tag, " latency"}, pt[0] - t_last, 4);
        chk({tag, " A"},       {A_R, A_G, A_B}, a);
        chk({tag, " InvR"},    Inv_A_R, ir);
        chk({tag, " InvG"},    Inv_A_G, ig);
        chk({tag, " InvB"},    Inv_A_B, ib);
        chk({tag, " hold"},    n_hold_viol, 0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " A"},   {A_R, A_G, A_B}, 0);
        chk({tag, " Inv"}, {Inv_A_R, Inv_A_G, Inv_A_B}, 0);
        chk({tag, " vld"}, output_is_valid, 0);
    endtask

    task automatic frame27();
        fill(24'hC80AC8);
        fb[5] = 24'h505A46;
    endtask

    initial begin
        // Reset with active input: outputs must stay cleared.
        input_pixel = 24'hFFFFFF;
        input_is_valid = 1'b1;
        repeat (3) @(negedge clk);
        check_zero("reset");
        drive(24'h0, 1'b0);
        rst = 1'b1;
        idle(2);

        // All-black frame: saturated reciprocals.
        n_pulse = 0; n_hold_viol = 0;
        fill(24'h000000);
        send_frame(1'b0);
        idle(8);
        check_result("black", 24'h000000, 16'hFFFF, 16'hFFFF, 16'hFFFF);

        // Single dominant pixel.
        n_pulse = 0;
        frame27();
        send_frame(1'b0);
        idle(8);
        check_result("single", 24'h505A46, 16'h0333, 16'h02D8, 16'h03A8);

        // Tie on dark value 100: pixel 3 must win over pixel 9.
        n_pulse = 0;
        fill(24'hC80AC8);
        fb[3] = 24'h6496C8;
        fb[9] = 24'h7864FF;
        send_frame(1'b0);
        idle(8);
        check_result("tie", 24'h6496C8, 16'h028F, 16'h01B4, 16'h0147);

        // Same frame as "single" but with random idle gaps.
        n_pulse = 0;
        frame27();
        send_frame(1'b1);
        idle(8);
        check_result("gaps", 24'h505A46, 16'h0333, 16'h02D8, 16'h03A8);

        // Back-to-back frames with no gap.
        n_pulse = 0; n_hold_viol = 0;
        frame27();
        send_frame(1'b0);
        fill(24'hC80AC8);
        fb[8] = 24'hFFFFFF;
        send_frame(1'b0);
        idle(8);
        chk("b2b pulses",  n_pulse, 2);
        chk("b2b spacing", pt[1] - pt[0], 16);
        chk("b2b latency", pt[1] - t_last, 4);
        chk("b2b first A", pa[0], 24'h505A46);
        chk("b2b A",       {A_R, A_G, A_B}, 24'hFFFFFF);
        chk("b2b Inv",     {Inv_A_R, Inv_A_G, Inv_A_B}, {16'h0101, 16'h0101, 16'h0101});
        chk("b2b hold",    n_hold_viol, 0);

        // Reset mid-frame: partial frame discarded, first edge after release accepts.
        for (int i = 0; i < 7; i++) drive(24'hFFFFFF, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        input_is_valid = 1'b0;
        repeat (2) @(negedge clk);
        check_zero("midrst");
        n_pulse = 0; n_hold_viol = 0;
        frame27();
        rst = 1'b1;
        input_pixel = fb[0];
        input_is_valid = 1'b1;
        for (int i = 1; i < 16; i++) drive(fb[i], 1'b1);
        t_last = cyc;
        idle(8);
        check_result("midrst", 24'h505A46, 16'h0333, 16'h02D8, 16'h03A8);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
